// File: rtl/game_pkg.sv
// game_pkg: shared game encodings, board defaults, settings addresses and planter states
package game_pkg;
    localparam logic [2:0]  PLAY                = 3'd2;
    localparam int          M_ROW_COLUMN_NUMBER = 16;
    localparam int          M_MINE_NUM          = 40;
    localparam logic [15:0] ADR_SIZE            = 16'd1;
    localparam logic [15:0] ADR_MINES           = 16'd2;
    localparam logic [15:0] LFSR_SEED           = 16'hACE1;
    typedef enum logic [2:0] {IDLE, READ_SETTINGS, PLANT, WRITE_BOARD, DONE} planter_state_t;
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: single-master Wishbone bus with stall, named from the master side
//   master: drives cyc_o/stb_o/we_o/adr_o/dat_o, receives dat_i/ack_i/stall_i
interface wishbone_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [15:0] adr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;
    logic        stall_i;
    modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i, stall_i);
    modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i, stall_i);
endinterface

// File: rtl/mine_lfsr.sv
// mine_lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11
//   clk, rst (async active-low, loads LFSR_SEED), en (advance), load (take seed), seed, q (state)
module mine_lfsr
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= LFSR_SEED;
        else if (load)
            q <= seed;
        else if (en)
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
endmodule

// File: rtl/mine_planter.sv
// mine_planter: reads board size/mine count, places mines pseudo-randomly, writes the board
//   clk, rst (async active-low), main_state (game FSM state), planting_complete (high in DONE)
//   game_set_wb (reads settings: adr 1 = size, adr 2 = mines), game_board_wb (one write per cell)
//   MINE_PLANTER_COUNTER_SEED_EN: mixes a free-running counter into the seed at each start
module mine_planter
    import game_pkg::*;
#(
    parameter int MAX_SIZE = M_ROW_COLUMN_NUMBER
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] main_state,
    output logic       planting_complete,
    wishbone_if.master game_set_wb,
    wishbone_if.master game_board_wb
);
    localparam int NC = MAX_SIZE * MAX_SIZE;
    localparam int CW = $clog2(NC + 1);
    localparam int IW = $clog2(NC);
    localparam int SW = $clog2(MAX_SIZE + 1);

    planter_state_t planter_state;
    logic [1:0]    step, gap;
    logic [SW-1:0] size, size_c, row, col;
    logic [CW-1:0] cells, mines, mine_c, remaining, cand, idx, nxt, wr_idx;
    logic [NC-1:0] bitmap;
    logic          retry, play, lfsr_en, lfsr_load;
    logic          set_stb, brd_stb, brd_dat;
    logic [15:0]   set_adr, brd_adr, lfsr_q, seed;

    assign play   = main_state == PLAY;
    assign cells  = CW'(size) * CW'(size);
    assign size_c = (game_set_wb.dat_i == 16'd0) ? SW'(1) :
                    (game_set_wb.dat_i > 16'(MAX_SIZE)) ? SW'(MAX_SIZE) : SW'(game_set_wb.dat_i);
    assign mine_c = (game_set_wb.dat_i > 16'(cells - CW'(1))) ? cells - CW'(1) : CW'(game_set_wb.dat_i);
    // a collision retries the next cell; only a successful placement consumes an LFSR value
    assign idx    = retry ? cand : CW'(lfsr_q % 16'(cells));
    assign nxt    = (idx + CW'(1) == cells) ? '0 : idx + CW'(1);

    assign lfsr_load = planter_state == IDLE && play;
    assign lfsr_en   = planter_state == PLANT && play && remaining != '0 && !bitmap[idx[IW-1:0]];

`ifdef MINE_PLANTER_COUNTER_SEED_EN
    logic [15:0] free_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            free_cnt <= '0;
        else
            free_cnt <= free_cnt + 16'd1;
    end
    assign seed = ((free_cnt ^ LFSR_SEED) == 16'd0) ? LFSR_SEED : free_cnt ^ LFSR_SEED;
`else
    assign seed = LFSR_SEED;
`endif

    mine_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .load (lfsr_load),
        .seed (seed),
        .q    (lfsr_q)
    );

    assign planting_complete     = planter_state == DONE;
    assign game_set_wb.cyc_o     = set_stb;
    assign game_set_wb.stb_o     = set_stb;
    assign game_set_wb.we_o      = 1'b0;
    assign game_set_wb.adr_o     = set_adr;
    assign game_set_wb.dat_o     = '0;
    assign game_board_wb.cyc_o   = brd_stb;
    assign game_board_wb.stb_o   = brd_stb;
    assign game_board_wb.we_o    = brd_stb;
    assign game_board_wb.adr_o   = brd_adr;
    assign game_board_wb.dat_o   = {15'd0, brd_dat};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            planter_state <= IDLE;
            step          <= '0;
            gap           <= '0;
            size          <= SW'(1);
            mines         <= '0;
            remaining     <= '0;
            bitmap        <= '0;
            cand          <= '0;
            retry         <= 1'b0;
            wr_idx        <= '0;
            row           <= '0;
            col           <= '0;
            set_stb       <= 1'b0;
            set_adr       <= '0;
            brd_stb       <= 1'b0;
            brd_adr       <= '0;
            brd_dat       <= 1'b0;
        end else begin
            case (planter_state)
                IDLE: begin
                    if (play) begin
                        planter_state <= READ_SETTINGS;
                        step          <= '0;
                        gap           <= '0;
                    end
                end
                READ_SETTINGS: begin
                    if (set_stb) begin
                        // an outstanding read always completes before an abort takes effect
                        if (game_set_wb.ack_i) begin
                            set_stb <= 1'b0;
                            set_adr <= '0;
                            gap     <= 2'd2;
                            step    <= step + 2'd1;
                            if (step == 2'd0)
                                size <= size_c;
                            else
                                mines <= mine_c;
                            if (!play)
                                planter_state <= IDLE;
                        end
                    end else if (!play) begin
                        planter_state <= IDLE;
                    end else if (gap != 2'd0) begin
                        gap <= gap - 2'd1;
                    end else if (step == 2'd2) begin
                        planter_state <= PLANT;
                        bitmap        <= '0;
                        remaining     <= mines;
                        retry         <= 1'b0;
                    end else begin
                        set_stb <= 1'b1;
                        set_adr <= (step == 2'd0) ? ADR_SIZE : ADR_MINES;
                    end
                end
                PLANT: begin
                    if (!play) begin
                        planter_state <= IDLE;
                    end else if (remaining == '0) begin
                        planter_state <= WRITE_BOARD;
                        wr_idx        <= '0;
                        row           <= '0;
                        col           <= '0;
                    end else if (!bitmap[idx[IW-1:0]]) begin
                        bitmap[idx[IW-1:0]] <= 1'b1;
                        remaining           <= remaining - CW'(1);
                        retry               <= 1'b0;
                    end else begin
                        cand  <= nxt;
                        retry <= 1'b1;
                    end
                end
                WRITE_BOARD: begin
                    if (brd_stb) begin
                        if (game_board_wb.ack_i) begin
                            brd_stb <= 1'b0;
                            brd_adr <= '0;
                            brd_dat <= 1'b0;
                            wr_idx  <= wr_idx + CW'(1);
                            col     <= (col + SW'(1) == size) ? '0 : col + SW'(1);
                            row     <= (col + SW'(1) == size) ? row + SW'(1) : row;
                            if (!play)
                                planter_state <= IDLE;
                            else if (wr_idx == cells - CW'(1))
                                planter_state <= DONE;
                        end
                    end else if (!play) begin
                        planter_state <= IDLE;
                    end else begin
                        brd_stb <= 1'b1;
                        brd_adr <= 16'(row) * 16'(MAX_SIZE) + 16'(col);
                        brd_dat <= bitmap[wr_idx[IW-1:0]];
                    end
                end
                DONE: begin
                    if (!play)
                        planter_state <= IDLE;
                end
                default: planter_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mine_planter.sv
// tb_mine_planter: scoreboard bench for mine_planter (settings reads, planting, board writes, stall, reset abort)
module tb_mine_planter;
    import game_pkg::*;

    typedef struct {
        logic [15:0] adr;
        logic        dat;
    } wr_t;

    logic         clk, rst, pc;
    logic [2:0]   main_state;
    wishbone_if   sw ();
    wishbone_if   bw ();

    wr_t          wq[$];
    logic [15:0]  sq[$];
    wr_t          e;
    logic [15:0]  se;
    logic         set_prev;
    int           errors, checks, n_wr, n_ones, plant_cyc;
    logic [255:0] lay_act, lay1, exp_bm;
    logic [15:0]  held;

    mine_planter #(.MAX_SIZE(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .main_state        (main_state),
        .planting_complete (pc),
        .game_set_wb       (sw),
        .game_board_wb     (bw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or negedge rst) begin
        if (!rst)
            bw.ack_i <= 1'b0;
        else
            bw.ack_i <= bw.stb_o && !bw.ack_i && !bw.stall_i;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bw.stb_o && bw.ack_i) begin
            n_wr++;
            if (bw.dat_o[0])
                n_ones++;
            lay_act[bw.adr_o[7:0]] = bw.dat_o[0];
            if (wq.size() == 0) begin
                chk("extra_write", {240'd0, bw.adr_o}, 256'hFFFF_FFFF);
            end else begin
                e = wq.pop_front();
                chk("wr_adr", bw.adr_o, e.adr);
                chk("wr_dat", bw.dat_o, {15'd0, e.dat});
                chk("wr_we", bw.we_o, 1);
            end
        end
        if (sw.stb_o && !set_prev) begin
            if (sq.size() == 0) begin
                chk("extra_read", {240'd0, sw.adr_o}, 256'hFFFF_FFFF);
            end else begin
                se = sq.pop_front();
                chk("rd_adr", sw.adr_o, se);
                chk("rd_we", sw.we_o, 0);
            end
        end
        set_prev = sw.stb_o;
    end

    function automatic logic [255:0] model(input int sz, input int mn);
        logic [255:0] bm = '0;
        logic [15:0]  r = 16'hACE1;
        int cells = sz * sz, rem = mn, i = 0, cand = 0;
        bit retry = 0;
        while (rem > 0) begin
            i = retry ? cand : int'(r) % cells;
            if (!bm[i]) begin
                bm[i] = 1'b1;
                rem--;
                r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
                retry = 0;
            end else begin
                cand = (i + 1) % cells;
                retry = 1;
            end
        end
        return bm;
    endfunction

    task automatic run_settings(input logic [15:0] sz, input logic [15:0] mn);
        sq.push_back(16'd1);
        sq.push_back(16'd2);
        main_state = PLAY;
        @(posedge clk); #1;
        chk("st_read", dut.planter_state, READ_SETTINGS);
        chk("stb_early", sw.stb_o, 0);
        @(posedge clk); #1;
        chk("stb_size", sw.stb_o, 1);
        chk("cyc_size", sw.cyc_o, 1);
        chk("adr_size", sw.adr_o, 1);
        chk("we_size", sw.we_o, 0);
        sw.dat_i = sz;
        sw.ack_i = 1'b1;
        @(posedge clk); #1;
        sw.ack_i = 1'b0;
        chk("stb_drop", sw.stb_o, 0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("gap_idle", sw.stb_o, 0);
        @(posedge clk); #1;
        chk("stb_mine", sw.stb_o, 1);
        chk("adr_mine", sw.adr_o, 2);
        sw.dat_i = mn;
        sw.ack_i = 1'b1;
        @(posedge clk); #1;
        sw.ack_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_plant", dut.planter_state, READ_SETTINGS);
        @(posedge clk); #1;
        chk("st_plant", dut.planter_state, PLANT);
    endtask

    task automatic do_run(input int raw_sz, input int raw_mn, input int sz, input int mn);
        wr_t w;
        exp_bm  = model(sz, mn);
        lay_act = '0;
        n_wr    = 0;
        n_ones  = 0;
        for (int k = 0; k < sz * sz; k++) begin
            w.adr = 16'((k / sz) * 16 + k % sz);
            w.dat = exp_bm[k];
            wq.push_back(w);
        end
        run_settings(16'(raw_sz), 16'(raw_mn));
    endtask

    task automatic wait_done(input int limit);
        int c = 0;
        while (!pc && c < limit) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_reached", pc, 1);
        chk("st_done", dut.planter_state, DONE);
    endtask

    task automatic leave_play();
        main_state = 3'd0;
        @(posedge clk); #1;
        chk("back_idle", dut.planter_state, IDLE);
        chk("pc_low", pc, 0);
    endtask

    initial begin
        errors = 0; checks = 0; n_wr = 0; n_ones = 0; set_prev = 1'b0;
        rst = 1'b0; main_state = 3'd0;
        sw.ack_i = 1'b0; sw.stall_i = 1'b0; sw.dat_i = '0;
        bw.stall_i = 1'b0; bw.dat_i = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_state", dut.planter_state, IDLE);
        chk("rst_set_stb", {sw.cyc_o, sw.stb_o, sw.we_o}, 0);
        chk("rst_set_adr", sw.adr_o, 0);
        chk("rst_brd_stb", {bw.cyc_o, bw.stb_o, bw.we_o}, 0);
        chk("rst_brd_adr", bw.adr_o, 0);
        chk("rst_brd_dat", bw.dat_o, 0);
        chk("rst_pc", pc, 0);
        chk("rst_bitmap", dut.bitmap, 0);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst = 1'b1;
        @(posedge clk); #1;

        // full 16x16 / 40 run with a mid-write stall
        do_run(M_ROW_COLUMN_NUMBER, M_MINE_NUM, 16, 40);
        plant_cyc = 0;
        repeat (100) begin
            if (dut.planter_state == PLANT)
                plant_cyc++;
            @(posedge clk); #1;
        end
        chk("st_write", dut.planter_state, WRITE_BOARD);
        chk("mine_count", $countones(dut.bitmap), 40);
        chk("bitmap", dut.bitmap, exp_bm);
        chk("plant_le95", plant_cyc <= 95 && plant_cyc > 40, 1);
        begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(bw.stb_o && !bw.ack_i) && w < 50);
            chk("stall_start", bw.stb_o && !bw.ack_i, 1);
            bw.stall_i = 1'b1;
            held = bw.adr_o;
            repeat (5) begin
                @(negedge clk);
                chk("stall_stb", bw.stb_o, 1);
                chk("stall_adr", bw.adr_o, held);
                chk("stall_ack", bw.ack_i, 0);
            end
            bw.stall_i = 1'b0;
        end
        wait_done(1300);
        chk("writes", n_wr, 256);
        chk("ones", n_ones, 40);
        chk("wq_empty", wq.size(), 0);
        chk("layout", lay_act, exp_bm);
        lay1 = lay_act;
        leave_play();

        // reset during PLANT, then a rerun must reproduce the layout
        run_settings(16'd16, 16'd40);
        repeat (5) @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_state", dut.planter_state, IDLE);
        chk("abort_set", {sw.cyc_o, sw.stb_o, sw.we_o}, 0);
        chk("abort_brd", {bw.cyc_o, bw.stb_o, bw.we_o}, 0);
        chk("abort_bitmap", dut.bitmap, 0);
        main_state = 3'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_run(16, 40, 16, 40);
        wait_done(1500);
        chk("writes2", n_wr, 256);
        chk("same_layout", lay_act, lay1);
        chk("wq_empty2", wq.size(), 0);
        leave_play();

        // size 0 clamps to 1, which forces the mine count to 0
        do_run(0, 5, 1, 0);
        wait_done(50);
        chk("writes3", n_wr, 1);
        chk("ones3", n_ones, 0);
        leave_play();

        // 3x3 board with mines clamped from 20 to 8
        do_run(3, 20, 3, 8);
        wait_done(200);
        chk("writes4", n_wr, 9);
        chk("ones4", n_ones, 8);
        chk("wq_empty4", wq.size(), 0);
        leave_play();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
